// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serializer feeding the serial sequence detector.
package seq_serializer_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/seq_serializer_hold_buf.sv
// Single-entry word buffer that lets the next word wait while the current one shifts.
module seq_hold_buf
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_take,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Capture a word on write and track occupancy; write and take never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (i_write) begin
        r_data <= i_data;
        r_full <= 1'b1;
      end else if (i_take) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder: words in over valid/ready, one bit per advancing clock out.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             advance,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last_bit,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  ser_state_e       r_state;
  ser_state_e       w_stateNext;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shiftNext;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_countNext;
  logic             r_wordDone;
  logic             w_holdFull;
  logic [WIDTH-1:0] w_holdData;
  logic             w_holdWrite;
  logic             w_holdTake;
  logic             w_accept;
  logic             w_lastAdv;

  seq_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_write (w_holdWrite),
    .i_data  (load_data),
    .i_take  (w_holdTake),
    .o_full  (w_holdFull),
    .o_data  (w_holdData)
  );

  assign load_ready = ~w_holdFull;
  assign w_accept   = load_valid & load_ready;
  assign ser_valid  = (r_state == SER_SHIFT);
  assign last_bit   = ser_valid & (r_count == LAST_IDX);
  assign w_lastAdv  = last_bit & advance;
  assign ser_out    = ser_valid & (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
  assign word_done  = r_wordDone;
  assign w_shifted  = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

  // Next-state logic: load, shift, hand over from hold or bypass, or fall back to idle.
  always_comb begin
    w_stateNext = r_state;
    w_shiftNext = r_shift;
    w_countNext = r_count;
    w_holdWrite = 1'b0;
    w_holdTake  = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (w_accept) begin
          w_shiftNext = load_data;
          w_countNext = '0;
          w_stateNext = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (w_lastAdv) begin
          w_countNext = '0;
          if (w_holdFull) begin
            w_shiftNext = w_holdData;
            w_holdTake  = 1'b1;
          end else if (w_accept) begin
            w_shiftNext = load_data;
          end else begin
            w_shiftNext = '0;
            w_stateNext = SER_IDLE;
          end
        end else begin
          if (advance) begin
            w_shiftNext = w_shifted;
            w_countNext = r_count + CW'(1);
          end
          if (w_accept) begin
            w_holdWrite = 1'b1;
          end
        end
      end
      default: w_stateNext = SER_IDLE;
    endcase
  end

  // State, shift register, bit counter and the word-done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= SER_IDLE;
      r_shift    <= '0;
      r_count    <= '0;
      r_wordDone <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_shift    <= w_shiftNext;
      r_count    <= w_countNext;
      r_wordDone <= w_lastAdv;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: LSB-first and MSB-first instances driven by the same inputs.
module tb_seq_serializer;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] loadData;
  logic         loadValid;
  logic         advance;
  logic         loadReady, serOut, serValid, lastBit, wordDone;
  logic         loadReadyM, serOutM, serValidM, lastBitM, wordDoneM;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference state: current word with bits remaining, one pending word, done pulse.
  logic [W-1:0] mCur;
  logic [W-1:0] mPend;
  int           mRem;
  bit           mPendFull;
  bit           mDone;

  typedef struct {
    logic         lv;
    logic [W-1:0] data;
    logic         adv;
    logic         expOut;
    logic         expValid;
    logic         expLast;
    logic         expDone;
    logic         expReady;
  } vec_t;

  vec_t vecs[18];
  int   bitsExp[16] = '{0,1,1,1,1,0,1,1,1,0,1,0,0,1,1,0};

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_data  (loadData),
    .load_valid (loadValid),
    .load_ready (loadReady),
    .advance    (advance),
    .ser_out    (serOut),
    .ser_valid  (serValid),
    .last_bit   (lastBit),
    .word_done  (wordDone)
  );

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutM (
    .clk        (clk),
    .rst        (rst),
    .load_data  (loadData),
    .load_valid (loadValid),
    .load_ready (loadReadyM),
    .advance    (advance),
    .ser_out    (serOutM),
    .ser_valid  (serValidM),
    .last_bit   (lastBitM),
    .word_done  (wordDoneM)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mCur = '0; mPend = '0; mRem = 0; mPendFull = 0; mDone = 0;
  endtask

  // One clock of the stream: consume a bit, queue an accepted word, refill when empty.
  task automatic modelStep(input logic lv, input logic [W-1:0] data, input logic adv);
    bit acc;
    acc   = lv && !mPendFull;
    mDone = (mRem > 0) && adv && (mRem == 1);
    if (mRem > 0 && adv) mRem--;
    if (acc) begin
      mPend = data;
      mPendFull = 1;
    end
    if (mRem == 0 && mPendFull) begin
      mCur = mPend;
      mRem = W;
      mPendFull = 0;
    end
  endtask

  task automatic checkOutput();
    logic expL, expM;
    expL = (mRem > 0) ? mCur[W - mRem] : 1'b0;
    expM = (mRem > 0) ? mCur[mRem - 1] : 1'b0;
    checkBit("serValid", serValid, mRem > 0);
    checkBit("serOut", serOut, expL);
    checkBit("lastBit", lastBit, mRem == 1);
    checkBit("wordDone", wordDone, mDone);
    checkBit("loadReady", loadReady, !mPendFull);
    checkBit("serValidM", serValidM, mRem > 0);
    checkBit("serOutM", serOutM, expM);
    checkBit("lastBitM", lastBitM, mRem == 1);
    checkBit("wordDoneM", wordDoneM, mDone);
    checkBit("loadReadyM", loadReadyM, !mPendFull);
  endtask

  // Drive one cycle of inputs, advance the model, then compare just after the edge.
  task automatic applyStimulus(input logic lv, input logic [W-1:0] data, input logic adv);
    loadValid = lv;
    loadData  = data;
    advance   = adv;
    @(posedge clk);
    modelStep(lv, data, adv);
    #1;
    checkOutput();
    cyc++;
  endtask

  initial begin
    int validCnt;
    int doneQ[$];
    int startCyc;

    rst = 1'b1; loadValid = 1'b0; loadData = '0; advance = 1'b0;
    modelReset();
    #1 rst = 1'b0;

    // Reset holds everything at rest even with a word offered.
    loadValid = 1'b1; loadData = 16'h1234; advance = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkBit("rstSerValid", serValid, 1'b0);
    checkBit("rstSerOut", serOut, 1'b0);
    checkBit("rstLastBit", lastBit, 1'b0);
    checkBit("rstWordDone", wordDone, 1'b0);
    checkBit("rstLoadReady", loadReady, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b1, 16'h1234, 1'b1);
    checkBit("acceptAfterReset", serValid, 1'b1);
    repeat (17) applyStimulus(1'b0, '0, 1'b1);

    // Single word 16'h65DE against the literal bit sequence.
    for (int i = 0; i < 16; i++) begin
      vecs[i].lv = (i == 0); vecs[i].data = 16'h65DE; vecs[i].adv = 1'b1;
      vecs[i].expOut = bitsExp[i][0]; vecs[i].expValid = 1'b1;
      vecs[i].expLast = (i == 15); vecs[i].expDone = 1'b0; vecs[i].expReady = 1'b1;
    end
    for (int i = 16; i < 18; i++) begin
      vecs[i].lv = 1'b0; vecs[i].data = '0; vecs[i].adv = 1'b1;
      vecs[i].expOut = 1'b0; vecs[i].expValid = 1'b0; vecs[i].expLast = 1'b0;
      vecs[i].expDone = (i == 16); vecs[i].expReady = 1'b1;
    end
    for (int i = 0; i < 18; i++) begin
      loadValid = vecs[i].lv; loadData = vecs[i].data; advance = vecs[i].adv;
      @(posedge clk);
      modelStep(vecs[i].lv, vecs[i].data, vecs[i].adv);
      #1;
      checkBit($sformatf("vecOut%0d", i), serOut, vecs[i].expOut);
      checkBit($sformatf("vecValid%0d", i), serValid, vecs[i].expValid);
      checkBit($sformatf("vecLast%0d", i), lastBit, vecs[i].expLast);
      checkBit($sformatf("vecDone%0d", i), wordDone, vecs[i].expDone);
      checkBit($sformatf("vecReady%0d", i), loadReady, vecs[i].expReady);
    end

    // MSB-first instance on 16'h8001: a one, fourteen zeros, a one.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i == 0, 16'h8001, 1'b1);
      checkBit($sformatf("msbBit%0d", i), serOutM, (i == 0) || (i == 15));
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkBit("msbDone", wordDoneM, 1'b1);

    // Back-to-back words with the second parked in the hold buffer.
    validCnt = 0; doneQ.delete(); startCyc = cyc;
    for (int k = 1; k <= 36; k++) begin
      applyStimulus(k <= 2, (k == 1) ? 16'hFFFF : 16'h0000, 1'b1);
      if (k == 2) checkBit("readyHoldFull", loadReady, 1'b0);
      if (serValid) validCnt++;
      if (wordDone) doneQ.push_back(cyc - startCyc);
    end
    checkInt("b2bValidCount", validCnt, 32);
    checkInt("b2bDoneCount", doneQ.size(), 2);
    if (doneQ.size() == 2) begin
      checkInt("b2bDoneFirst", doneQ[0], 17);
      checkInt("b2bDoneSecond", doneQ[1], 33);
    end

    // Stall for five cycles with bit 3 of 16'h00F0 on the line.
    validCnt = 0;
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(k == 1, 16'h00F0, !(k >= 5 && k <= 9));
      if (serValid) validCnt++;
      if (k >= 5 && k <= 9) checkBit($sformatf("stallBit%0d", k), serOut, 1'b0);
    end
    checkInt("stallValidCount", validCnt, 21);

    // Bypass on the last bit with an empty hold buffer.
    applyStimulus(1'b1, 16'hA5C3, 1'b1);
    repeat (15) applyStimulus(1'b0, '0, 1'b1);
    checkBit("bypassLast", lastBit, 1'b1);
    applyStimulus(1'b1, 16'h3C5B, 1'b1);
    checkBit("bypassValid", serValid, 1'b1);
    checkBit("bypassBit0", serOut, 1'b1);
    checkBit("bypassDone", wordDone, 1'b1);
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 16'h1111, 1'b1);

    // Asynchronous reset mid-word drops the stream and the held word immediately.
    #2 rst = 1'b0;
    #1;
    checkBit("midRstValid", serValid, 1'b0);
    checkBit("midRstReady", loadReady, 1'b1);
    checkBit("midRstLast", lastBit, 1'b0);
    @(posedge clk);
    #1;
    checkBit("midRstNoDone", wordDone, 1'b0);
    modelReset();
    rst = 1'b1;

    // Random traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 9) < 4, W'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
